// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states, default limits, x0 address.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERR      = 2'd3
  } hz_state_t;

  localparam int unsigned DEF_FLUSH_CYCLES = 1;
  localparam int unsigned DEF_MEM_TIMEOUT  = 16;
  localparam logic [4:0]  REG_ADDR_ZERO    = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus between the ID/EX/MEM stages and hazard_ctrl.
// master: the controller (drives pipeline controls); slave: the pipeline.
interface hazard_ctrl_if;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic [1:0] id_rs_use;
  logic [4:0] ex_rd_addr;
  logic       ex_load;
  logic       ex_jmp_taken;
  logic       mem_req;
  logic       mem_ack;
  logic       stall_pc;
  logic       stall_if_id;
  logic       bubble_id_ex;
  logic       flush_if_id;
  logic       stall_ex_mem;
  logic       mem_timeout_err;

  modport master (
    input  id_rs1_addr, id_rs2_addr, id_rs_use, ex_rd_addr, ex_load,
           ex_jmp_taken, mem_req, mem_ack,
    output stall_pc, stall_if_id, bubble_id_ex, flush_if_id, stall_ex_mem,
           mem_timeout_err
  );

  modport slave (
    output id_rs1_addr, id_rs2_addr, id_rs_use, ex_rd_addr, ex_load,
           ex_jmp_taken, mem_req, mem_ack,
    input  stall_pc, stall_if_id, bubble_id_ex, flush_if_id, stall_ex_mem,
           mem_timeout_err
  );
endinterface

// File: rtl/hazard_ctrl_cmp.sv
// hazard_cmp: combinational load-use detector; matches the EX load destination against ID sources.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic [1:0] id_rs_use,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_load,
  output logic       load_use
);
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_rs_use[0] && (id_rs1_addr == ex_rd_addr);
    rs2_hit  = id_rs_use[1] && (id_rs2_addr == ex_rd_addr);
    // x0 is hard-wired zero, so a load targeting it never produces a hazard.
    load_use = ex_load && (ex_rd_addr != REG_ADDR_ZERO) && (rs1_hit || rs2_hit);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory freeze, jump flush and load-use stall for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt cycle counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int unsigned MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt,
`endif
  hazard_ctrl_if.master       bus
);
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  hz_state_t         state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic mem_wait;
  logic stall_pc_c, stall_if_id_c, bubble_c, flush_c, stall_ex_mem_c, err_c;

  hazard_cmp u_cmp (
    .id_rs1_addr (bus.id_rs1_addr),
    .id_rs2_addr (bus.id_rs2_addr),
    .id_rs_use   (bus.id_rs_use),
    .ex_rd_addr  (bus.ex_rd_addr),
    .ex_load     (bus.ex_load),
    .load_use    (load_use)
  );

  assign mem_wait = bus.mem_req && !bus.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    stall_pc_c     = 1'b0;
    stall_if_id_c  = 1'b0;
    bubble_c       = 1'b0;
    flush_c        = 1'b0;
    stall_ex_mem_c = 1'b0;
    err_c          = 1'b0;

    unique case (state_q)
      S_RUN, S_FLUSH: begin
        if (mem_wait) begin
          stall_pc_c     = 1'b1;
          stall_if_id_c  = 1'b1;
          stall_ex_mem_c = 1'b1;
          wait_cnt_d     = '0;
          state_d        = S_MEM_WAIT;
        end else if (bus.ex_jmp_taken || state_q == S_FLUSH) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          // A new taken jump (re)loads the hold counter with the cycles remaining after this one.
          if (bus.ex_jmp_taken) begin
            if (FLUSH_CYCLES > 1) begin
              flush_cnt_d = 3'(FLUSH_CYCLES - 1);
              state_d     = S_FLUSH;
            end else begin
              state_d = S_RUN;
            end
          end else if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = '0;
            state_d     = S_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end else if (load_use) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          bubble_c      = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        if (bus.mem_ack) begin
          // Pipe advances this cycle; a load-use pair frozen behind the access is caught here.
          state_d = S_RUN;
          if (load_use) begin
            stall_pc_c    = 1'b1;
            stall_if_id_c = 1'b1;
            bubble_c      = 1'b1;
          end
        end else begin
          stall_pc_c     = 1'b1;
          stall_if_id_c  = 1'b1;
          stall_ex_mem_c = 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      S_ERR: begin
        stall_pc_c     = 1'b1;
        stall_if_id_c  = 1'b1;
        stall_ex_mem_c = 1'b1;
        err_c          = 1'b1;
      end

      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    bus.stall_pc        = rst_n && stall_pc_c;
    bus.stall_if_id     = rst_n && stall_if_id_c;
    bus.bubble_id_ex    = rst_n && bubble_c;
    bus.flush_if_id     = rst_n && flush_c;
    bus.stall_ex_mem    = rst_n && stall_ex_mem_c;
    bus.mem_timeout_err = rst_n && err_c;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc_c) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_c)    perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
